sw_debounce: RTL
================

// Module: sw_debounce
// PURPOSE
//  Input-conditioning stage that sits directly upstream of the 8-to-3 priority encoder / 7-seg path.
//  Synchronises the eight raw slide-switch code bits and the enable switch to i_clk.
//  Debounces each bit independently and presents glitch-free levels on o_code/o_en, which connect
//  straight to the encoder's i_code/i_en.
//  o_chg is a one-cycle strobe marking any change, for downstream latching/logging.
// PARAMETERS
//  DB_CYCLES  50000  consecutive synced cycles a new level must hold before it is accepted (>=2)
//  CNT_W      16     per-bit counter width; must satisfy 2**CNT_W > DB_CYCLES-1
// PORTS
//  i_clk      in   1  system clock, all logic on rising edge
//  i_rst_n    in   1  synchronous reset, active-low
//  i_code     in   8  raw asynchronous switch code bits
//  i_en       in   1  raw asynchronous enable switch
//  o_code     out  8  debounced code, feeds encoder i_code
//  o_en       out  1  debounced enable, feeds encoder i_en
//  o_chg      out  1  one-cycle pulse: some o_code/o_en bit changed this cycle
// BEHAVIOUR
//  - Treat {i_en,i_code} as 9 identical lanes b=0..8; lane logic is replicated, no cross-lane coupling.
//  - Per lane, 2-FF synchroniser: s1<=raw; s2<=s1. Stable register q drives the output bit.
//  - Per-lane counter cnt[CNT_W-1:0], evaluated each edge:
//    - s2==q                     : cnt<=0.
//    - s2!=q, cnt<DB_CYCLES-1    : cnt<=cnt+1.
//    - s2!=q, cnt==DB_CYCLES-1   : q<=s2; cnt<=0.
//  - Any mismatch gap (s2 returns to q) clears cnt, so a pulse shorter than DB_CYCLES synced cycles is discarded.
//  - Latency: raw level first sampled by s1 at edge k and held steady -> q updates at edge k+1+DB_CYCLES.
//    Example: DB_CYCLES=4 -> update at edge k+5.
//  - o_chg: registered.
//    - High for exactly the cycle following any edge where at least one lane's q toggled.
//    - Asserted in the same cycle the new o_code/o_en value is first visible.
//    - Several lanes toggling on the same edge -> one single-cycle pulse.
//    - Back-to-back lane toggles on consecutive edges -> o_chg stays high for both cycles.
//  - Reset (i_rst_n==0 at an edge): s1,s2,q,cnt of all lanes <=0; o_code=8'h00, o_en=0, o_chg=0.
//    - Reset overrides all counting.
//    - Reset mid-count aborts the count; no partial count survives.
//  - No combinational path from any input to any output; all outputs are registered.
//  - cnt never exceeds DB_CYCLES-1, so no wrap-around.
//  - DB_CYCLES<2 is unsupported (elaboration-time check).
// TESTING (bench overrides DB_CYCLES=4, CNT_W=3)
//  1 Reset: i_rst_n=0 for 3 edges with i_code=8'hFF, i_en=1
//    -> o_code=8'h00, o_en=0, o_chg=0 throughout reset.
//  2 Clean step: i_code 00->08, first sampled at edge k
//    -> o_code=8'h08 visible after edge k+5; o_chg=1 for exactly that one cycle; no earlier change.
//  3 Glitch: i_code[2] high for 3 cycles, then low
//    -> o_code stays 8'h00, o_chg never asserts.
//  4 Bounce: i_code[7] toggles every cycle for 6 cycles, then held 1 from edge j
//    -> o_code[7] rises after edge j+5 only; single o_chg pulse.
//  5 Simultaneous: i_code 00->81 and i_en 0->1 on the same edge
//    -> o_code=8'h81 and o_en=1 appear on the same cycle; exactly one o_chg pulse.
//  6 Reset mid-count: i_code=8'h10 held, i_rst_n pulsed low 1 cycle two edges after sampling
//    -> outputs held 0; o_code=8'h10 appears 5 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: synchronises and debounces eight switch code bits plus the enable switch.
// Each of the nine lanes has a 2-FF synchroniser and a mismatch counter. A new level is
// accepted only after it has held for DB_CYCLES consecutive synchronised cycles.
// o_chg is a registered one-cycle strobe that is high while a newly accepted level is
// first visible on the outputs.
module sw_debounce #(
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_code,
   input  logic       i_en,
   output logic [7:0] o_code,
   output logic       o_en,
   output logic       o_chg
);

   localparam int LANES = 9;
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

   logic [LANES-1:0] w_raw;
   logic [LANES-1:0] w_q;
   logic [LANES-1:0] w_tog;
   logic             r_chg;

   // Reject parameter sets the counter cannot represent.
   if ((DB_CYCLES < 2) || ((64'd1 << CNT_W) <= 64'(DB_CYCLES - 1))) begin : g_bad_param
      $error("sw_debounce: DB_CYCLES must be >= 2 and fit in CNT_W bits");
   end

   // Lane b = 8 is the enable switch; lanes 0..7 are the code bits.
   assign w_raw = {i_en, i_code};

   genvar gi;
   for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane
      logic             r_s1;
      logic             r_s2;
      logic             r_q;
      logic [CNT_W-1:0] r_cnt;

      // Synchronise the raw bit, then count consecutive mismatches against the stable level.
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_q   <= 1'b0;
            r_cnt <= '0;
         end else begin
            r_s1 <= w_raw[gi];
            r_s2 <= r_s1;
            if (r_s2 == r_q) begin
               r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
               r_q   <= r_s2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end

      assign w_q[gi]   = r_q;
      // Marks the edge on which this lane's stable level will flip.
      assign w_tog[gi] = (r_s2 != r_q) && (r_cnt == LP_LAST);
   end

   // Strobe registered alongside the stable levels so it coincides with the new value.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_chg <= 1'b0;
      end else begin
         r_chg <= |w_tog;
      end
   end

   assign o_code = w_q[7:0];
   assign o_en   = w_q[8];
   assign o_chg  = r_chg;

endmodule
